// File: rtl/aqed_pkg.sv
// Shared definitions for the A-QED duplicate-check monitor: FSM state
// encoding and default sizing constants.
package aqed_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ORIG = 2'd1,
      DUP  = 2'd2,
      DONE = 2'd3
   } aqed_state_e;

   localparam int unsigned AQED_DATA_W     = 16;
   localparam int unsigned AQED_CNT_W      = 17;
   localparam int unsigned AQED_RESP_BOUND = 64;

endpackage

// File: rtl/aqed_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment and the count holds at all-ones.
module aqed_sat_counter #(
   parameter int unsigned W = 17
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/aqed_dup_check.sv
// A-QED functional-consistency monitor: issues an original and a later
// duplicate of the same payload and compares the two accelerator results.
module aqed_dup_check
   import aqed_pkg::*;
#(
   parameter int unsigned DATA_W     = AQED_DATA_W,
   parameter int unsigned CNT_W      = AQED_CNT_W,
   parameter int unsigned RESP_BOUND = AQED_RESP_BOUND
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clk_en,
   input  logic [DATA_W-1:0] bmc_in_data,
   input  logic              bmc_in_valid,
   input  logic              bmc_orig_sel,
   input  logic              bmc_dup_sel,
   input  logic              acc_in_ready,
   output logic [DATA_W-1:0] acc_in_data,
   output logic              acc_in_valid,
   input  logic [DATA_W-1:0] acc_out_data,
   input  logic              acc_out_valid,
   output logic              orig_issued,
   output logic              orig_done,
   output logic              qed_done,
   output logic              qed_check,
   output logic              resp_timeout,
   output logic              protocol_err,
   output logic [CNT_W-1:0]  in_after_orig
);

   aqed_state_e       state_q, state_d;
   logic [CNT_W-1:0]  in_cnt, out_cnt;
   logic [CNT_W-1:0]  orig_idx, dup_idx;
   logic [DATA_W-1:0] orig_data, orig_out, orig_ref;
   logic              xfer, res_valid, dup_issue;
   logic              orig_take, dup_take, orig_hit, dup_hit, proto_hit;

   assign xfer      = acc_in_valid & acc_in_ready & clk_en;
   assign res_valid = acc_out_valid & clk_en;
   assign dup_issue = (state_q == ORIG) & bmc_dup_sel;

   assign acc_in_valid = bmc_in_valid & (state_q != DONE);
   assign acc_in_data  = dup_issue ? orig_data : bmc_in_data;
   assign orig_issued  = (state_q != IDLE);

   // A saturated in_cnt could no longer index the original uniquely.
   assign orig_take = xfer & (state_q == IDLE) & bmc_orig_sel & (in_cnt != '1);
   assign dup_take  = xfer & dup_issue;
   assign orig_hit  = res_valid & orig_issued & ~orig_done & (out_cnt == orig_idx);
   assign dup_hit   = res_valid & (state_q == DUP) & (out_cnt == dup_idx);
   assign proto_hit = res_valid & (out_cnt == in_cnt);
   assign orig_ref  = orig_hit ? acc_out_data : orig_out;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (orig_take) state_d = ORIG;
         ORIG: if (dup_take)  state_d = DUP;
         DUP:  if (dup_hit)   state_d = DONE;
         DONE: state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else if (clk_en) begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         orig_data    <= '0;
         orig_idx     <= '0;
         dup_idx      <= '0;
         orig_out     <= '0;
         orig_done    <= 1'b0;
         qed_done     <= 1'b0;
         qed_check    <= 1'b0;
         resp_timeout <= 1'b0;
         protocol_err <= 1'b0;
      end else if (clk_en) begin
         if (orig_take) begin
            orig_data <= bmc_in_data;
            orig_idx  <= in_cnt;
         end
         if (dup_take) begin
            dup_idx <= in_cnt;
         end
         if (orig_hit) begin
            orig_out  <= acc_out_data;
            orig_done <= 1'b1;
         end
         if (dup_hit) begin
            qed_done  <= 1'b1;
            qed_check <= (acc_out_data == orig_ref);
         end
         if ((in_after_orig >= CNT_W'(RESP_BOUND)) && !orig_done) begin
            resp_timeout <= 1'b1;
         end
         if (proto_hit) begin
            protocol_err <= 1'b1;
         end
      end
   end

   aqed_sat_counter #(.W(CNT_W)) u_in_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (1'b0),
      .inc     (xfer),
      .count   (in_cnt)
   );

   // A spurious result is not counted, so later results keep their indices.
   aqed_sat_counter #(.W(CNT_W)) u_out_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (1'b0),
      .inc     (res_valid & ~proto_hit),
      .count   (out_cnt)
   );

   aqed_sat_counter #(.W(CNT_W)) u_in_after_orig (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (1'b0),
      .inc     (xfer & orig_issued),
      .count   (in_after_orig)
   );

endmodule
